mem_port_sched: RTL
===================

MEM_PORT_SCHED -- requirements
Module: mem_port_sched

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, number of consecutive lost IF arbitrations before IF is forced to win (legal range 1..7).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 if_req_i / if_addr_i / if_mask_i  input  1/32/8  IF read request, address, byte mask.
REQ-005 if_rdata_o / if_rvalid_o  output  64/1  IF read data and one-cycle valid pulse.
REQ-006 mr_req_i / mr_addr_i / mr_mask_i  input  1/32/8  MEM read request, address, byte mask.
REQ-007 mr_rdata_o / mr_rvalid_o  output  64/1  MEM read data and one-cycle valid pulse.
REQ-008 mw_req_i / mw_addr_i / mw_mask_i / mw_wdata_i  input  1/32/8/64  MEM write request, address, byte mask, data.
REQ-009 mw_done_o  output  1  one-cycle write-complete pulse.
REQ-010 mem_req_o / mem_we_o / mem_addr_o / mem_mask_o / mem_wdata_o  output  1/1/32/8/64  downstream single-port request.
REQ-011 mem_gnt_i / mem_rvalid_i / mem_rdata_i  input  1/1/64  downstream accept, response/ack pulse, read data.

Function
REQ-012 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-013 In IDLE, requesters SHALL be sampled and one winner latched with its addr/mask/wdata/owner-ID; with no request, the FSM SHALL stay in IDLE.
REQ-014 Base priority SHALL be: MEM write > MEM read > IF.
REQ-015 IDLE with a winner SHALL go to ISSUE; mem_req_o SHALL be 1 only in ISSUE, driven from latched registers.
REQ-016 ISSUE SHALL hold mem_req_o and the payload stable until mem_gnt_i=1, then go to WAIT.
REQ-017 ISSUE with mem_gnt_i=1 and mem_rvalid_i=1 in the same cycle SHALL go straight to RESP.
REQ-018 WAIT SHALL stay until mem_rvalid_i=1, then latch mem_rdata_i and go to RESP.
REQ-019 RESP SHALL pulse exactly one of if_rvalid_o/mr_rvalid_o/mw_done_o for the owner, present latched data on that owner's rdata output, and return to IDLE.
REQ-020 Minimum request-to-response latency SHALL be 3 cycles: IDLE sample, ISSUE with gnt+rvalid, RESP pulse.
REQ-021 Requesters SHALL hold req and payload until their completion pulse; a requester that deasserts req before RESP SHALL still have its transaction completed downstream, with its completion pulse suppressed.
REQ-022 rdata outputs of non-owners SHALL be 0; a completion pulse SHALL last one cycle only.
REQ-023 mem_rvalid_i in IDLE or RESP SHALL be ignored.
REQ-024 A requester still asserted after its pulse SHALL be re-arbitrated in the following IDLE cycle, giving one transaction per 3 cycles minimum.

Reset
REQ-025 rst SHALL immediately force IDLE and set all outputs, latched payload, owner-ID and starvation counter to 0.
REQ-026 Reset during ISSUE/WAIT SHALL abandon the transaction with no completion pulse; a late mem_rvalid_i SHALL be ignored per REQ-023.

Configuration
REQ-027 With SCHED_ANTISTARVE_EN defined, a 3-bit counter SHALL increment each IDLE arbitration in which if_req_i=1 and IF loses, saturating at 7, and clear when IF wins or if_req_i=0.
REQ-028 With SCHED_ANTISTARVE_EN defined and counter >= STARVE_LIMIT, IF SHALL win over both MEM requesters.
REQ-029 Without SCHED_ANTISTARVE_EN, the counter SHALL not exist and REQ-014 priority SHALL be strict.

Verification
REQ-030 Zero-wait memory (gnt and rvalid in the ISSUE cycle), IF read addr 0x80000000, rdata 0x1122334455667788 -> if_rvalid_o pulses 3 cycles after if_req_i with that data; mr/mw outputs stay 0.
REQ-031 if_req_i, mr_req_i and mw_req_i all rise in the same cycle -> service order write, MEM read, IF; exactly one pulse each, 3 cycles apart.
REQ-032 mem_gnt_i delayed 2 cycles, rvalid 3 further cycles -> mem_req_o and payload stable throughout ISSUE; response 7 cycles after the request.
REQ-033 With SCHED_ANTISTARVE_EN, STARVE_LIMIT=4, mw_req_i held high and if_req_i held high -> IF is served at the 5th arbitration; without the macro, IF is never served.
REQ-034 rst asserted during WAIT, then mem_rvalid_i=1 -> outputs 0 asynchronously; no completion pulse; FSM in IDLE.
REQ-035 mr_req_i dropped during WAIT -> downstream transaction completes, mr_rvalid_o stays 0, and the next pending requester is served.

Source files
------------

// File: rtl/mem_port_sched.sv
// mem_port_sched: arbitrates an instruction-fetch read port (IF), a data read
// port (MR) and a data write port (MW) onto one single-port downstream memory.
// Only one downstream transaction is in flight at a time.
// Optional feature macro: SCHED_ANTISTARVE_EN forces IF to win after
// STARVE_LIMIT consecutive lost arbitrations.
module mem_port_sched #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic [7:0]  if_mask_i,
  output logic [63:0] if_rdata_o,
  output logic        if_rvalid_o,
  input  logic        mr_req_i,
  input  logic [31:0] mr_addr_i,
  input  logic [7:0]  mr_mask_i,
  output logic [63:0] mr_rdata_o,
  output logic        mr_rvalid_o,
  input  logic        mw_req_i,
  input  logic [31:0] mw_addr_i,
  input  logic [7:0]  mw_mask_i,
  input  logic [63:0] mw_wdata_i,
  output logic        mw_done_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [7:0]  mem_mask_o,
  output logic [63:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [63:0] mem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MR, OWN_MW} owner_t;

  state_t      r_state;
  state_t      w_state_next;
  owner_t      r_owner;
  owner_t      w_win_owner;
  logic [31:0] r_addr;
  logic [31:0] w_win_addr;
  logic [7:0]  r_mask;
  logic [7:0]  w_win_mask;
  logic [63:0] r_wdata;
  logic [63:0] w_win_wdata;
  logic [63:0] r_rdata;
  logic        r_we;
  logic        r_alive;       // owner has kept its request up; completion pulse allowed
  logic        w_latch_win;
  logic        w_latch_rdata;
  logic        w_force_if;
  logic        w_owner_req;
  logic        w_resp;

`ifdef SCHED_ANTISTARVE_EN
  logic [2:0] r_starve_cnt;

  assign w_force_if = if_req_i && (r_starve_cnt >= 3'(STARVE_LIMIT));

  // Count consecutive IDLE arbitrations that IF requested but lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (!if_req_i || (w_win_owner == OWN_IF)) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt != 3'd7) begin
        r_starve_cnt <= r_starve_cnt + 3'd1;
      end
    end
  end
`else
  // Without the counter the limit has no effect; it is referenced only so the
  // parameter stays connected in this build.
  assign w_force_if = (STARVE_LIMIT > 7) & 1'b0;
`endif

  // Pick the winner among current requesters: write > read > IF, unless IF is starving.
  always_comb begin
    w_win_owner = OWN_NONE;
    w_win_addr  = '0;
    w_win_mask  = '0;
    w_win_wdata = '0;
    if (w_force_if) begin
      w_win_owner = OWN_IF;
      w_win_addr  = if_addr_i;
      w_win_mask  = if_mask_i;
    end else if (mw_req_i) begin
      w_win_owner = OWN_MW;
      w_win_addr  = mw_addr_i;
      w_win_mask  = mw_mask_i;
      w_win_wdata = mw_wdata_i;
    end else if (mr_req_i) begin
      w_win_owner = OWN_MR;
      w_win_addr  = mr_addr_i;
      w_win_mask  = mr_mask_i;
    end else if (if_req_i) begin
      w_win_owner = OWN_IF;
      w_win_addr  = if_addr_i;
      w_win_mask  = if_mask_i;
    end
  end

  // Current request level of whoever owns the in-flight transaction.
  always_comb begin
    case (r_owner)
      OWN_IF:  w_owner_req = if_req_i;
      OWN_MR:  w_owner_req = mr_req_i;
      OWN_MW:  w_owner_req = mw_req_i;
      default: w_owner_req = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and all state-decoded outputs.
  always_comb begin
    w_state_next  = r_state;
    w_latch_win   = 1'b0;
    w_latch_rdata = 1'b0;
    mem_req_o     = 1'b0;
    w_resp        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_win_owner != OWN_NONE) begin
          w_latch_win  = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) begin
          if (mem_rvalid_i) begin
            w_latch_rdata = 1'b1;
            w_state_next  = S_RESP;
          end else begin
            w_state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          w_latch_rdata = 1'b1;
          w_state_next  = S_RESP;
        end
      end
      S_RESP: begin
        w_resp       = r_alive;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Latch the winning payload, track abandonment, capture response data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= OWN_NONE;
      r_addr  <= '0;
      r_mask  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_alive <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_latch_win) begin
        r_owner <= w_win_owner;
        r_addr  <= w_win_addr;
        r_mask  <= w_win_mask;
        r_wdata <= w_win_wdata;
        r_we    <= (w_win_owner == OWN_MW);
        r_alive <= 1'b1;
      end else if (((r_state == S_ISSUE) || (r_state == S_WAIT)) && !w_owner_req) begin
        r_alive <= 1'b0;
      end
      if (w_latch_rdata) begin
        r_rdata <= mem_rdata_i;
      end
    end
  end

  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_mask_o  = r_mask;
  assign mem_wdata_o = r_wdata;

  assign if_rvalid_o = w_resp && (r_owner == OWN_IF);
  assign mr_rvalid_o = w_resp && (r_owner == OWN_MR);
  assign mw_done_o   = w_resp && (r_owner == OWN_MW);
  assign if_rdata_o  = if_rvalid_o ? r_rdata : '0;
  assign mr_rdata_o  = mr_rvalid_o ? r_rdata : '0;

endmodule
